// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_responder_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    // Word returned for misaligned or out-of-range fetches (RV32 addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_mem_responder_imem_array.sv
// DEPTH_WORDS x 32 synchronous RAM: one write port, one registered read port.
// A same-edge read and write to one word returns the old contents. No reset.
module imem_array
    import instr_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write and read share the edge; non-blocking update gives read-before-write.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Fixed-latency responder for the fetch request/grant/valid interface,
// modelling a multi-cycle instruction memory with a program-load port.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        instr_req_ip,
    input  logic [31:0] instr_addr_ip,
    output logic        instr_gnt_op,
    output logic        instr_valid_op,
    output logic [31:0] instr_data_op,
    output logic        instr_err_op,
    input  logic        prog_we_ip,
    input  logic [31:0] prog_addr_ip,
    input  logic [31:0] prog_data_ip
);

    localparam int          ADDR_W = $clog2(DEPTH_WORDS);
    localparam int          CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;

    // True when a base-relative byte offset is misaligned or past the array.
    function automatic logic addr_bad(input logic [31:0] off);
        return (off[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
    endfunction

    imem_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              resp_err_q;
    logic              resp_loaded_q;

    logic [31:0]       fetch_off;
    logic [31:0]       prog_off;
    logic              fetch_err;
    logic              prog_ok;
    logic              enter_resp;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;
    logic [31:0]       ram_q;

    assign fetch_off = instr_addr_ip - BASE_ADDR;
    assign prog_off  = prog_addr_ip - BASE_ADDR;
    assign fetch_err = addr_bad(fetch_off);
    assign prog_ok   = prog_we_ip && !addr_bad(prog_off);

    assign instr_gnt_op = instr_req_ip && mem_en && !prog_we_ip && !reset &&
                          ((state == IMEM_IDLE) || (state == IMEM_RESP));

    // With single-cycle latency the read happens on the grant edge itself,
    // so the live decode is used instead of the latched copy.
    assign enter_resp = !reset &&
                        (((LATENCY == 1) && instr_gnt_op) ||
                         ((state == IMEM_WAIT) && (cnt == '0)));
    assign rd_addr    = (LATENCY == 1) ? fetch_off[ADDR_W+1:2] : addr_q;
    assign rd_err     = (LATENCY == 1) ? fetch_err : err_q;

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (prog_ok),
        .wr_addr (prog_off[ADDR_W+1:2]),
        .wr_data (prog_data_ip),
        .rd_en   (enter_resp && !rd_err),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Request FSM, latency countdown and latched address/error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IMEM_IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            err_q         <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_loaded_q <= 1'b0;
        end else begin
            if (instr_gnt_op) begin
                addr_q <= fetch_off[ADDR_W+1:2];
                err_q  <= fetch_err;
                if (LATENCY == 1) begin
                    state <= IMEM_RESP;
                end else begin
                    state <= IMEM_WAIT;
                    cnt   <= CNT_W'(LATENCY - 2);
                end
            end else begin
                case (state)
                    IMEM_WAIT: begin
                        if (cnt == '0) begin
                            state <= IMEM_RESP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    IMEM_RESP: state <= IMEM_IDLE;
                    default:   state <= IMEM_IDLE;
                endcase
            end
            if (enter_resp) begin
                resp_err_q    <= rd_err;
                resp_loaded_q <= 1'b1;
            end
        end
    end

    // Response word holds until the next response; zero until the first one.
    always_comb begin
        instr_valid_op = (state == IMEM_RESP);
        instr_err_op   = resp_loaded_q && resp_err_q;
        instr_data_op  = 32'h0;
        if (resp_loaded_q) begin
            instr_data_op = resp_err_q ? NOP_INSTR : ram_q;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder with LATENCY=2, DEPTH_WORDS=1024.
module tb_instr_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        instr_req_ip;
    logic [31:0] instr_addr_ip;
    logic        instr_gnt_op;
    logic        instr_valid_op;
    logic [31:0] instr_data_op;
    logic        instr_err_op;
    logic        prog_we_ip;
    logic [31:0] prog_addr_ip;
    logic [31:0] prog_data_ip;

    int errors = 0;
    int checks = 0;

    instr_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_en         (mem_en),
        .instr_req_ip   (instr_req_ip),
        .instr_addr_ip  (instr_addr_ip),
        .instr_gnt_op   (instr_gnt_op),
        .instr_valid_op (instr_valid_op),
        .instr_data_op  (instr_data_op),
        .instr_err_op   (instr_err_op),
        .prog_we_ip     (prog_we_ip),
        .prog_addr_ip   (prog_addr_ip),
        .prog_data_ip   (prog_data_ip)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        prog_we_ip   = 1'b1;
        prog_addr_ip = addr;
        prog_data_ip = data;
        tick();
        prog_we_ip   = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        mem_en        = 1'b1;
        instr_req_ip  = 1'b1;
        instr_addr_ip = 32'h0;
        prog_we_ip    = 1'b0;
        prog_addr_ip  = 32'h0;
        prog_data_ip  = 32'h0;
        tick();
        tick();
        #1;
        checks++;
        if (instr_gnt_op !== 1'b0) begin
            errors++; $display("FAIL reset_gnt: got %b expected 0", instr_gnt_op);
        end
        checks++;
        if (instr_valid_op !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid_op);
        end
        checks++;
        if (instr_data_op !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 00000000", instr_data_op);
        end
        checks++;
        if (instr_err_op !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", instr_err_op);
        end
        instr_req_ip = 1'b0;
        reset        = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        load(32'h0C, 32'hDEADBEEF);
        // cycle N
        instr_req_ip  = 1'b1;
        instr_addr_ip = 32'h0C;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b1) begin
            errors++; $display("FAIL basic_gnt_n: got %b expected 1", instr_gnt_op);
        end
        tick();
        // cycle N+1: request still held, must not be granted while waiting
        #1;
        checks++;
        if (instr_gnt_op !== 1'b0) begin
            errors++; $display("FAIL basic_gnt_n1: got %b expected 0", instr_gnt_op);
        end
        checks++;
        if (instr_valid_op !== 1'b0) begin
            errors++; $display("FAIL basic_valid_n1: got %b expected 0", instr_valid_op);
        end
        tick();
        // cycle N+2
        instr_req_ip = 1'b0;
        checks++;
        if (instr_valid_op !== 1'b1) begin
            errors++; $display("FAIL basic_valid_n2: got %b expected 1", instr_valid_op);
        end
        checks++;
        if (instr_data_op !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_data: got %h expected deadbeef", instr_data_op);
        end
        checks++;
        if (instr_err_op !== 1'b0) begin
            errors++; $display("FAIL basic_err: got %b expected 0", instr_err_op);
        end
        tick();
        // cycle N+3: pulse ends, data holds
        checks++;
        if (instr_valid_op !== 1'b0) begin
            errors++; $display("FAIL basic_valid_n3: got %b expected 0", instr_valid_op);
        end
        checks++;
        if (instr_data_op !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_hold: got %h expected deadbeef", instr_data_op);
        end
    endtask

    task automatic test_back_to_back();
        load(32'h0, 32'h11);
        load(32'h4, 32'h22);
        // cycle N
        instr_req_ip  = 1'b1;
        instr_addr_ip = 32'h0;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b1) begin
            errors++; $display("FAIL b2b_gnt0: got %b expected 1", instr_gnt_op);
        end
        tick();
        // cycle N+1: next request presented, busy
        instr_addr_ip = 32'h4;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b0) begin
            errors++; $display("FAIL b2b_gnt1: got %b expected 0", instr_gnt_op);
        end
        tick();
        // cycle N+2: first response and second grant together
        #1;
        checks++;
        if (instr_valid_op !== 1'b1 || instr_data_op !== 32'h11) begin
            errors++; $display("FAIL b2b_resp0: got valid=%b data=%h expected valid=1 data=00000011",
                               instr_valid_op, instr_data_op);
        end
        checks++;
        if (instr_gnt_op !== 1'b1) begin
            errors++; $display("FAIL b2b_gnt2: got %b expected 1", instr_gnt_op);
        end
        tick();
        // cycle N+3
        instr_req_ip = 1'b0;
        checks++;
        if (instr_valid_op !== 1'b0) begin
            errors++; $display("FAIL b2b_valid3: got %b expected 0", instr_valid_op);
        end
        tick();
        // cycle N+4
        checks++;
        if (instr_valid_op !== 1'b1 || instr_data_op !== 32'h22) begin
            errors++; $display("FAIL b2b_resp1: got valid=%b data=%h expected valid=1 data=00000022",
                               instr_valid_op, instr_data_op);
        end
        tick();
    endtask

    task automatic test_error();
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h6;
        bad_addr[1] = 32'd4096;
        for (int i = 0; i < 2; i++) begin
            instr_req_ip  = 1'b1;
            instr_addr_ip = bad_addr[i];
            #1;
            checks++;
            if (instr_gnt_op !== 1'b1) begin
                errors++; $display("FAIL err_gnt[%0d]: got %b expected 1", i, instr_gnt_op);
            end
            tick();
            instr_req_ip = 1'b0;
            tick();
            checks++;
            if (instr_valid_op !== 1'b1 || instr_data_op !== 32'h13 || instr_err_op !== 1'b1) begin
                errors++; $display("FAIL err_resp[%0d]: got valid=%b data=%h err=%b expected 1/00000013/1",
                                   i, instr_valid_op, instr_data_op, instr_err_op);
            end
            tick();
        end
    endtask

    task automatic test_mem_en();
        mem_en        = 1'b0;
        instr_req_ip  = 1'b1;
        instr_addr_ip = 32'h0C;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (instr_gnt_op !== 1'b0) begin
                errors++; $display("FAIL men_blocked[%0d]: got %b expected 0", i, instr_gnt_op);
            end
            tick();
        end
        mem_en = 1'b1;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b1) begin
            errors++; $display("FAIL men_gnt: got %b expected 1", instr_gnt_op);
        end
        tick();
        mem_en       = 1'b0;
        instr_req_ip = 1'b0;
        tick();
        checks++;
        if (instr_valid_op !== 1'b1 || instr_data_op !== 32'hDEADBEEF) begin
            errors++; $display("FAIL men_resp: got valid=%b data=%h expected 1/deadbeef",
                               instr_valid_op, instr_data_op);
        end
        mem_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        instr_req_ip  = 1'b1;
        instr_addr_ip = 32'h0C;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b1) begin
            errors++; $display("FAIL rmid_gnt: got %b expected 1", instr_gnt_op);
        end
        tick();
        instr_req_ip = 1'b0;
        reset        = 1'b1;
        tick();
        checks++;
        if (instr_valid_op !== 1'b0 || instr_data_op !== 32'h0 || instr_err_op !== 1'b0) begin
            errors++; $display("FAIL rmid_abort: got valid=%b data=%h err=%b expected 0/00000000/0",
                               instr_valid_op, instr_data_op, instr_err_op);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (instr_valid_op !== 1'b0) begin
            errors++; $display("FAIL rmid_after: got %b expected 0", instr_valid_op);
        end
    endtask

    task automatic test_prog_collision();
        load(32'h14, 32'h1);
        // cycle N: grant read of word 5
        instr_req_ip  = 1'b1;
        instr_addr_ip = 32'h14;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b1) begin
            errors++; $display("FAIL col_gnt: got %b expected 1", instr_gnt_op);
        end
        tick();
        // cycle N+1: write on the edge entering the response
        instr_req_ip = 1'b0;
        prog_we_ip   = 1'b1;
        prog_addr_ip = 32'h14;
        prog_data_ip = 32'hA5A5A5A5;
        tick();
        prog_we_ip = 1'b0;
        checks++;
        if (instr_valid_op !== 1'b1 || instr_data_op !== 32'h1) begin
            errors++; $display("FAIL col_old: got valid=%b data=%h expected 1/00000001",
                               instr_valid_op, instr_data_op);
        end
        tick();
        // re-read sees the new word
        instr_req_ip = 1'b1;
        tick();
        instr_req_ip = 1'b0;
        tick();
        checks++;
        if (instr_valid_op !== 1'b1 || instr_data_op !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL col_new: got valid=%b data=%h expected 1/a5a5a5a5",
                               instr_valid_op, instr_data_op);
        end
        tick();
        // program load blocks grants while idle
        prog_we_ip   = 1'b1;
        prog_addr_ip = 32'h14;
        prog_data_ip = 32'hA5A5A5A5;
        instr_req_ip = 1'b1;
        #1;
        checks++;
        if (instr_gnt_op !== 1'b0) begin
            errors++; $display("FAIL prog_block: got %b expected 0", instr_gnt_op);
        end
        tick();
        prog_we_ip   = 1'b0;
        instr_req_ip = 1'b0;
        tick();
        checks++;
        if (instr_valid_op !== 1'b0) begin
            errors++; $display("FAIL prog_block_valid: got %b expected 0", instr_valid_op);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_error();
        test_mem_en();
        test_reset_mid();
        test_prog_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Responder end of the fetch-to-instruction-memory request/grant/valid interface. It accepts one word-fetch request per grant and returns the instruction word after a fixed, parameterised latency. It sits beside the fetch stage and models a multi-cycle instruction DRAM. It also exposes a program-load write port for bench and boot initialisation.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words; power of two.
LATENCY, 2, cycles from the grant cycle to the valid cycle; must be 1 or greater.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
mem_en  in  1  enables acceptance of new requests
instr_req_ip  in  1  fetch request valid
instr_addr_ip  in  32  fetch byte address
instr_gnt_op  out  1  request accepted this cycle (combinational)
instr_valid_op  out  1  response word valid, one-cycle pulse
instr_data_op  out  32  response instruction word
instr_err_op  out  1  response is for a misaligned or out-of-range address; qualified by valid
prog_we_ip  in  1  program-load write enable
prog_addr_ip  in  32  program-load byte address
prog_data_ip  in  32  program-load word

Behaviour:
- Clocking and reset: reset is synchronous, active-high; the clock is clock.
- Reset values:
  - instr_valid_op = 0, instr_data_op = 0, instr_err_op = 0.
  - Internal state = IMEM_IDLE, latency counter = 0, latched address = 0.
  - instr_gnt_op = 0 while reset is high.
  - Memory array contents are not reset.
- States:
  - IMEM_IDLE: no request in flight.
  - IMEM_WAIT: request in flight, counter counting down.
  - IMEM_RESP: valid cycle.
- Grant rule: instr_gnt_op = instr_req_ip && mem_en && !prog_we_ip && !reset && (state is IMEM_IDLE or IMEM_RESP).
- Grant at cycle N:
  - The edge ending N latches the address and error flag.
  - If LATENCY == 1, next state is IMEM_RESP. Otherwise next state is IMEM_WAIT with counter = LATENCY-2.
- IMEM_WAIT: decrement the counter each cycle. When the counter is 0, the next state is IMEM_RESP.
- Response timing:
  - instr_valid_op is high exactly in cycle N+LATENCY, for one cycle.
  - instr_data_op and instr_err_op are registered at the edge entering IMEM_RESP.
  - instr_data_op holds its value after the valid cycle until the next response.
- Leaving IMEM_RESP: if granted in that cycle, follow the grant transition above (back-to-back); otherwise go to IMEM_IDLE. Maximum throughput is one response per LATENCY cycles.
- Address decode:
  - offset = instr_addr_ip - BASE_ADDR, in 32-bit wrap-around arithmetic.
  - word index = offset[31:2].
  - Error if offset[1:0] != 0 or offset >= DEPTH_WORDS*4.
  - On error: instr_data_op = 32'h0000_0013 (NOP) and instr_err_op = 1. The array is not read.
- Array read: the read occurs at the edge entering IMEM_RESP (read-before-write).
  - A prog write on that same edge to the same word returns the old data.
  - A write on any earlier edge is visible.
- Program load:
  - A write occurs at the edge when prog_we_ip = 1 and the address is aligned and in range; otherwise it is silently dropped.
  - prog_we_ip suppresses grants but does not stall an in-flight response.
- mem_en low: blocks new grants only. An in-flight request still completes.
- Reset mid-operation: aborts the in-flight request. No valid pulse is produced; outputs return to reset values on the next edge.
- Requests while busy: instr_req_ip in IMEM_WAIT gets no grant. The requester must hold req and addr until granted; the address is sampled only in the grant cycle.

Decomposition:
- CORE_PKG additions:
  - typedef enum logic [1:0] imem_state_e {IMEM_IDLE, IMEM_WAIT, IMEM_RESP}.
  - localparam NOP_INSTR = 32'h0000_0013.
- One sub-module, imem_array: DEPTH_WORDS x 32 synchronous RAM with one write port and one read port, read-before-write on a same-address collision, no reset.
- The FSM, counter and address decode stay in instr_mem_responder.

Test Plan:
- LATENCY=2: load word 3 = 32'hDEADBEEF; req with addr 32'h0C at cycle 10 -> gnt=1 at cycle 10, valid=1 with data 32'hDEADBEEF and err=0 at cycle 12, gnt=0 at cycle 11.
- Back-to-back with req held high at addrs 0x0 then 0x4 (words 0x11, 0x22) -> grants at cycles 10 and 12; valid at cycles 12 (0x11) and 14 (0x22).
- Misaligned addr 0x6, and out-of-range addr DEPTH_WORDS*4 -> valid at N+2 with data 32'h00000013 and err=1.
- mem_en=0 with req=1 for 5 cycles -> gnt stays 0; raise mem_en at cycle 15 -> grant at cycle 15, valid at cycle 17. Drop mem_en one cycle after a grant -> response still arrives.
- Reset asserted at N+1 after a grant at N -> no valid at N+2; valid, data and err = 0.
- prog_we_ip=1 writing word 5 = 0xA5A5A5A5 on the edge entering IMEM_RESP for a read of word 5 (old value 0x1) -> response 0x1. Re-read -> 0xA5A5A5A5. A req while prog_we_ip=1 -> no grant.
